// File: rtl/obstacle_track_if.sv
// Obstacle word handshake between the sequence generator and the track reader.
// The producer drives seq/seq_valid and holds them until seq_ready is seen.
interface obstacle_track_if;
  logic [0:15] seq;
  logic        seq_valid;
  logic        seq_ready;

  modport master (
    output seq,
    output seq_valid,
    input  seq_ready
  );

  modport slave (
    input  seq,
    input  seq_valid,
    output seq_ready
  );
endinterface

// File: rtl/obstacle_track_reader.sv
// Car Dash obstacle track reader: splits 16-bit obstacle words into two rows,
// scrolls them down a ROWS-deep track, checks the player column against the
// bottom row and keeps a saturating run score.
module obstacle_track_reader #(
  parameter int ROWS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_tick,
  obstacle_track_if.slave   bus,
  input  logic [2:0]        player_col,
  output logic [ROWS*8-1:0] track,
  output logic              crash,
  output logic [15:0]       score,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RUN     = 2'd2,
    CRASHED = 2'd3
  } state_t;

  localparam int            CW        = $clog2(ROWS + 1);
  localparam logic [CW-1:0] FILL_LAST = CW'(ROWS - 1);
  localparam logic [7:0]    WALL_ROW  = 8'b1000_0001;

  state_t        cur_state;
  state_t        nxt_state;
  logic [15:0]   seq_word;
  logic [15:0]   stage_word;
  logic          stage_half;
  logic          stage_full;
  logic [CW-1:0] fill_cnt;
  logic [7:0]    bottom_row;
  logic [7:0]    ins_row;
  logic          collision;
  logic          accept;
  logic          do_insert;
  logic          do_clear;
  logic          do_score;

  assign bus.seq_ready = !stage_full && (cur_state == FILL || cur_state == RUN);
  assign accept        = bus.seq_valid && bus.seq_ready;
  assign bottom_row    = track[(ROWS-1)*8 +: 8];
  assign collision     = bottom_row[player_col];
  assign crash         = (cur_state == CRASHED);
  assign state         = cur_state;

  // Re-pack the ascending seq bus so bit c of each byte is column c of its row.
  always_comb begin
    seq_word = '0;
    for (int i = 0; i < 16; i++) begin
      seq_word[i] = bus.seq[i];
    end
  end

  // Row pushed on an insert: the pending half of the stage, or a wall row if empty.
  always_comb begin
    ins_row = WALL_ROW;
    if (stage_full) begin
      ins_row = stage_half ? stage_word[15:8] : stage_word[7:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next state and per-cycle actions; a collision beats a simultaneous step.
  always_comb begin
    nxt_state = cur_state;
    do_insert = 1'b0;
    do_clear  = 1'b0;
    do_score  = 1'b0;
    case (cur_state)
      IDLE, CRASHED: begin
        if (start) begin
          nxt_state = FILL;
          do_clear  = 1'b1;
        end
      end
      FILL: begin
        if (stage_full) begin
          do_insert = 1'b1;
          if (fill_cnt == FILL_LAST) begin
            nxt_state = RUN;
          end
        end
      end
      RUN: begin
        if (collision) begin
          nxt_state = CRASHED;
        end else if (step_tick) begin
          do_insert = 1'b1;
          do_score  = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Track, score and fill counter: cleared at run start, updated on each insert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track    <= '0;
      score    <= '0;
      fill_cnt <= '0;
    end else if (do_clear) begin
      track    <= '0;
      score    <= '0;
      fill_cnt <= '0;
    end else if (do_insert) begin
      track <= {track[(ROWS-1)*8-1:0], ins_row};
      if (do_score && score != 16'hFFFF) begin
        score <= score + 16'd1;
      end
      if (cur_state == FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Staging register: loads a word on accept, frees itself after row B is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_word <= '0;
      stage_half <= 1'b0;
      stage_full <= 1'b0;
    end else if (accept) begin
      stage_word <= seq_word;
      stage_half <= 1'b0;
      stage_full <= 1'b1;
    end else if (do_insert && stage_full) begin
      if (stage_half) begin
        stage_half <= 1'b0;
        stage_full <= 1'b0;
      end else begin
        stage_half <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_track_reader.sv
// Scoreboard bench for obstacle_track_reader: a row-queue reference model
// predicts the outputs after every clock edge, a monitor compares them.
module tb_obstacle_track_reader;

  localparam int ROWS = 8;
  localparam int W    = ROWS * 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          step_tick;
  logic [2:0]    player_col;
  logic [W-1:0]  track;
  logic          crash;
  logic [15:0]   score;
  logic [1:0]    state;

  obstacle_track_if bus_if();

  obstacle_track_reader #(.ROWS(ROWS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .step_tick  (step_tick),
    .bus        (bus_if),
    .player_col (player_col),
    .track      (track),
    .crash      (crash),
    .score      (score),
    .state      (state)
  );

  typedef struct packed {
    logic [W-1:0] trk;
    logic [15:0]  scr;
    logic [1:0]   st;
    logic         crs;
    logic         rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_track [ROWS];
  logic [7:0] m_pending[$];
  int         m_state;
  int         m_score;
  int         m_fill;
  int         compared   = 0;
  int         mismatched = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:15] mk_word(input logic [7:0] row_a, input logic [7:0] row_b);
    logic [0:15] w;
    for (int c = 0; c < 8; c++) begin
      w[c]     = row_a[c];
      w[8 + c] = row_b[c];
    end
    return w;
  endfunction

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_run();
    for (int r = 0; r < ROWS; r++) m_track[r] = 8'h00;
    m_score = 0;
    m_fill  = 0;
  endtask

  task automatic model_reset();
    model_clear_run();
    m_state = 0;
    m_pending.delete();
  endtask

  task automatic model_push_row(input logic [7:0] row);
    for (int r = ROWS - 1; r > 0; r--) m_track[r] = m_track[r - 1];
    m_track[0] = row;
  endtask

  // One game cycle at the spec level: rows queue up from accepted words and
  // scroll into the track; states are plain numbers 0..3.
  task automatic model_step();
    logic [0:15] sb;
    logic [7:0]  row_a;
    logic [7:0]  row_b;
    logic [W-1:0] flat;
    bit          rdy;
    exp_t        e;
    rdy = (m_pending.size() == 0) && (m_state == 1 || m_state == 2);
    case (m_state)
      0, 3: begin
        if (start) begin
          model_clear_run();
          m_state = 1;
        end
      end
      1: begin
        if (m_pending.size() > 0) begin
          model_push_row(m_pending.pop_front());
          m_fill++;
          if (m_fill == ROWS) m_state = 2;
        end
      end
      default: begin
        if (m_track[ROWS-1][player_col]) begin
          m_state = 3;
        end else if (step_tick) begin
          if (m_pending.size() > 0) model_push_row(m_pending.pop_front());
          else model_push_row(8'h81);
          if (m_score < 65535) m_score++;
        end
      end
    endcase
    if (rdy && bus_if.seq_valid) begin
      sb = bus_if.seq;
      for (int c = 0; c < 8; c++) begin
        row_a[c] = sb[c];
        row_b[c] = sb[8 + c];
      end
      m_pending.push_back(row_a);
      m_pending.push_back(row_b);
    end
    for (int r = 0; r < ROWS; r++) flat[r*8 +: 8] = m_track[r];
    e.trk = flat;
    e.scr = m_score[15:0];
    e.st  = m_state[1:0];
    e.crs = (m_state == 3);
    e.rdy = (m_pending.size() == 0) && (m_state == 1 || m_state == 2);
    exp_q.push_back(e);
  endtask

  // Reference model: advances on every clock edge, resets with rst_n.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compares the DUT against the oldest prediction mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("track", track, e.trk);
        check_output("score", score, e.scr);
        check_output("state", state, e.st);
        check_output("crash", crash, e.crs);
        check_output("seq_ready", bus_if.seq_ready, e.rdy);
      end
    end
  end

  task automatic apply_stimulus(input bit st, input bit stp, input logic [2:0] pc);
    start      = st;
    step_tick  = stp;
    player_col = pc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    step_tick = 1'b0;
  endtask

  task automatic send_word(input logic [0:15] w);
    bit rdy;
    int n;
    n = 0;
    bus_if.seq       = w;
    bus_if.seq_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = bus_if.seq_ready;
      @(posedge clk);
      #1;
      n++;
      if (rdy) break;
      if (n >= 50) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL send_word_timeout: got no seq_ready expected acceptance within 50 cycles");
        break;
      end
    end
  endtask

  task automatic wait_model_state(input int target, input int budget, input bit stp,
                                  input logic [2:0] pc, input string name);
    int n;
    n = 0;
    while (m_state != target && n < budget) begin
      apply_stimulus(1'b0, stp, pc);
      n++;
    end
    if (m_state != target) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got state %0d expected %0d within %0d cycles", name, m_state, target, budget);
    end
  endtask

  task automatic fill_walls();
    for (int i = 0; i < ROWS / 2; i++) send_word(mk_word(8'h81, 8'h81));
    bus_if.seq_valid = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish expected completion before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    bit will_acc;
    rst_n            = 1'b0;
    start            = 1'b0;
    step_tick        = 1'b0;
    player_col       = 3'd0;
    bus_if.seq_valid = 1'b0;
    bus_if.seq       = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (2) apply_stimulus(1'b0, 1'b0, 3'd0);
    check_output("idle_state", state, 2'd0);
    check_output("idle_track", track, '0);
    check_output("idle_score", score, 16'd0);
    check_output("idle_crash", crash, 1'b0);
    check_output("idle_ready", bus_if.seq_ready, 1'b0);

    $display("[TB] fill with wall rows");
    apply_stimulus(1'b1, 1'b0, 3'd3);
    check_output("fill_entered", state, 2'd1);
    fill_walls();
    wait_model_state(2, 30, 1'b0, 3'd3, "fill_to_run");
    check_output("run_state", state, 2'd2);
    check_output("run_walls", track, {ROWS{8'h81}});
    check_output("run_ready", bus_if.seq_ready, 1'b1);

    $display("[TB] ten steps between walls");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 3'd3);
      repeat ($urandom_range(0, 2)) apply_stimulus(1'b0, 1'b0, 3'd3);
    end
    check_output("score_ten", score, 16'd10);
    check_output("walls_after_steps", track, {ROWS{8'h81}});

    $display("[TB] obstacle in column 3 scrolls to the bottom");
    send_word(mk_word(8'h81, 8'h89));
    bus_if.seq_valid = 1'b0;
    wait_model_state(3, 40, 1'b1, 3'd3, "step_to_crash");
    check_output("crash_flag", crash, 1'b1);
    check_output("crash_state", state, 2'd3);
    repeat (5) apply_stimulus(1'b0, 1'b1, 3'd3);

    $display("[TB] wall collision in column 0");
    apply_stimulus(1'b1, 1'b0, 3'd0);
    fill_walls();
    wait_model_state(3, 40, 1'b0, 3'd0, "wall_crash");
    check_output("wall_crash_flag", crash, 1'b1);

    $display("[TB] restart from crash and saturate score");
    apply_stimulus(1'b1, 1'b0, 3'd3);
    check_output("restart_state", state, 2'd1);
    check_output("restart_score", score, 16'd0);
    check_output("restart_track", track, '0);
    check_output("restart_crash", crash, 1'b0);
    fill_walls();
    wait_model_state(2, 30, 1'b0, 3'd3, "refill_to_run");
    repeat (65540) apply_stimulus(1'b0, 1'b1, 3'd3);
    check_output("score_saturated", score, 16'hFFFF);
    check_output("sat_crash", crash, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_state", state, 2'd0);
    check_output("arst_track", track, '0);
    check_output("arst_score", score, 16'd0);
    check_output("arst_crash", crash, 1'b0);
    check_output("arst_ready", bus_if.seq_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] randomized play");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      will_acc = bus_if.seq_valid && bus_if.seq_ready;
      @(posedge clk);
      #1;
      if (will_acc || !bus_if.seq_valid) begin
        bus_if.seq_valid = ($urandom_range(0, 3) != 0);
        bus_if.seq       = 16'($urandom() & $urandom() & $urandom());
      end
      start     = ($urandom_range(0, 19) == 0);
      step_tick = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) player_col = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    start            = 1'b0;
    step_tick        = 1'b0;
    bus_if.seq_valid = 1'b0;
    repeat (3) apply_stimulus(1'b0, 1'b0, player_col);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
